// File: rtl/collision_scanner.sv
// collision_scanner: per-frame sequential collision engine emitting one hit event at a time on a valid/ready stream.
// Optional macro COLLISION_SHIP_EN adds the ship/asteroid phase and the ship_hit flag.
module collision_scanner #(
    parameter int MAX_ASTEROIDS = 3,
    parameter int MAX_SHOTS     = 3,
    parameter int ENTITY_SIZE   = 34,
    parameter int SCREEN_W      = 320,
    parameter int SCREEN_H      = 240,
    parameter int AST_SIZE      = 16,
    parameter int SHOT_SIZE     = 2,
    parameter int SHIP_SIZE     = 16
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic                                 start,
    input  logic [ENTITY_SIZE-1:0]               ship,
    input  logic [MAX_ASTEROIDS*ENTITY_SIZE-1:0] asteroids,
    input  logic [MAX_SHOTS*ENTITY_SIZE-1:0]     shots,
    output logic                                 evt_valid,
    input  logic                                 evt_ready,
    output logic [1:0]                           evt_type,
    output logic [9:0]                           evt_ast_addr,
    output logic [9:0]                           evt_shot_addr,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 ship_hit
);
    localparam int AIW = (MAX_ASTEROIDS > 1) ? $clog2(MAX_ASTEROIDS) : 1;
    localparam int SIW = (MAX_SHOTS > 1) ? $clog2(MAX_SHOTS) : 1;
    localparam logic [10:0] AST_W  = 11'(AST_SIZE);
    localparam logic [10:0] SHOT_W = 11'(SHOT_SIZE);
    localparam logic [10:0] LIM_X  = 11'(SCREEN_W);
    localparam logic [10:0] LIM_Y  = 11'(SCREEN_H);

    typedef enum logic [2:0] {IDLE, SNAP, SHIP, PAIR, OOB, EMIT, DONE} state_t;

    state_t                   state, ret_state, scan_next;
    logic [AIW-1:0]           ai;
    logic [SIW-1:0]           sj;
    logic                     ai_last, sj_last, cur_hit;
    logic [MAX_ASTEROIDS-1:0] ast_act, ast_kill;
    logic [9:0]               ast_x [MAX_ASTEROIDS];
    logic [9:0]               ast_y [MAX_ASTEROIDS];
    logic [MAX_SHOTS-1:0]     shot_act, shot_kill;
    logic [9:0]               shot_x [MAX_SHOTS];
    logic [9:0]               shot_y [MAX_SHOTS];
    logic                     unused_inputs;

    assign unused_inputs = ^{ship, asteroids, shots};

`ifdef COLLISION_SHIP_EN
    localparam logic [10:0] SHIP_W = 11'(SHIP_SIZE);
    logic       ship_act, ship_hit_r;
    logic [9:0] ship_x, ship_y;
    assign ship_hit = ship_hit_r;
`else
    assign ship_hit = 1'b0;
`endif

    // Top-left boxes; 11-bit sums so a box near x=1023 cannot wrap, and touching edges do not overlap.
    function automatic logic overlap(input logic [9:0] ax, input logic [9:0] ay, input logic [10:0] aw,
                                     input logic [9:0] bx, input logic [9:0] by, input logic [10:0] bw);
        return ({1'b0, ax} < {1'b0, bx} + bw) && ({1'b0, bx} < {1'b0, ax} + aw) &&
               ({1'b0, ay} < {1'b0, by} + bw) && ({1'b0, by} < {1'b0, ay} + aw);
    endfunction

    // Hit test and follow-on phase for the comparison made in the current cycle.
    always_comb begin
        ai_last   = (ai == AIW'(MAX_ASTEROIDS - 1));
        sj_last   = (sj == SIW'(MAX_SHOTS - 1));
        cur_hit   = 1'b0;
        scan_next = IDLE;
        case (state)
`ifdef COLLISION_SHIP_EN
            SHIP: begin
                cur_hit   = ship_act && ast_act[ai] && !ast_kill[ai] &&
                            overlap(ship_x, ship_y, SHIP_W, ast_x[ai], ast_y[ai], AST_W);
                scan_next = ai_last ? PAIR : SHIP;
            end
`endif
            PAIR: begin
                cur_hit   = ast_act[ai] && !ast_kill[ai] && shot_act[sj] && !shot_kill[sj] &&
                            overlap(ast_x[ai], ast_y[ai], AST_W, shot_x[sj], shot_y[sj], SHOT_W);
                scan_next = (ai_last && sj_last) ? OOB : PAIR;
            end
            OOB: begin
                cur_hit   = shot_act[sj] && !shot_kill[sj] &&
                            (({1'b0, shot_x[sj]} >= LIM_X) || ({1'b0, shot_y[sj]} >= LIM_Y));
                scan_next = sj_last ? DONE : OOB;
            end
            default: ;
        endcase
    end

    // Scan FSM: indices advance on every comparison; a hit parks in EMIT and resumes at ret_state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            ret_state     <= IDLE;
            ai            <= '0;
            sj            <= '0;
            ast_act       <= '0;
            ast_kill      <= '0;
            shot_act      <= '0;
            shot_kill     <= '0;
            evt_valid     <= 1'b0;
            evt_type      <= 2'd0;
            evt_ast_addr  <= 10'd0;
            evt_shot_addr <= 10'd0;
            busy          <= 1'b0;
            done          <= 1'b0;
            for (int i = 0; i < MAX_ASTEROIDS; i++) begin
                ast_x[i] <= 10'd0;
                ast_y[i] <= 10'd0;
            end
            for (int j = 0; j < MAX_SHOTS; j++) begin
                shot_x[j] <= 10'd0;
                shot_y[j] <= 10'd0;
            end
`ifdef COLLISION_SHIP_EN
            ship_act   <= 1'b0;
            ship_x     <= 10'd0;
            ship_y     <= 10'd0;
            ship_hit_r <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= SNAP;
                        busy  <= 1'b1;
                    end
                end
                SNAP: begin
                    for (int i = 0; i < MAX_ASTEROIDS; i++) begin
                        ast_act[i] <= asteroids[i*ENTITY_SIZE];
                        ast_x[i]   <= asteroids[i*ENTITY_SIZE+6 +: 10];
                        ast_y[i]   <= asteroids[i*ENTITY_SIZE+16 +: 10];
                    end
                    for (int j = 0; j < MAX_SHOTS; j++) begin
                        shot_act[j] <= shots[j*ENTITY_SIZE];
                        shot_x[j]   <= shots[j*ENTITY_SIZE+6 +: 10];
                        shot_y[j]   <= shots[j*ENTITY_SIZE+16 +: 10];
                    end
                    ast_kill  <= '0;
                    shot_kill <= '0;
                    ai        <= '0;
                    sj        <= '0;
`ifdef COLLISION_SHIP_EN
                    ship_act   <= ship[0];
                    ship_x     <= ship[15:6];
                    ship_y     <= ship[25:16];
                    ship_hit_r <= 1'b0;
                    state      <= SHIP;
`else
                    state <= PAIR;
`endif
                end
`ifdef COLLISION_SHIP_EN
                SHIP: begin
                    ai <= ai_last ? '0 : ai + 1'b1;
                    if (cur_hit) begin
                        ship_hit_r    <= 1'b1;
                        ast_kill[ai]  <= 1'b1;
                        evt_type      <= 2'd1;
                        evt_ast_addr  <= 10'(ai);
                        evt_shot_addr <= 10'd0;
                        evt_valid     <= 1'b1;
                        ret_state     <= scan_next;
                        state         <= EMIT;
                    end else begin
                        state <= scan_next;
                    end
                end
`endif
                PAIR: begin
                    if (sj_last) begin
                        sj <= '0;
                        ai <= ai_last ? '0 : ai + 1'b1;
                    end else begin
                        sj <= sj + 1'b1;
                    end
                    if (cur_hit) begin
                        ast_kill[ai]  <= 1'b1;
                        shot_kill[sj] <= 1'b1;
                        evt_type      <= 2'd0;
                        evt_ast_addr  <= 10'(ai);
                        evt_shot_addr <= 10'(sj);
                        evt_valid     <= 1'b1;
                        ret_state     <= scan_next;
                        state         <= EMIT;
                    end else begin
                        state <= scan_next;
                    end
                end
                OOB: begin
                    sj <= sj_last ? '0 : sj + 1'b1;
                    if (cur_hit) begin
                        shot_kill[sj] <= 1'b1;
                        evt_type      <= 2'd2;
                        evt_ast_addr  <= 10'd0;
                        evt_shot_addr <= 10'(sj);
                        evt_valid     <= 1'b1;
                        ret_state     <= scan_next;
                        state         <= EMIT;
                    end else begin
                        state <= scan_next;
                        done  <= (scan_next == DONE);
                    end
                end
                EMIT: begin
                    if (evt_ready) begin
                        evt_valid <= 1'b0;
                        state     <= ret_state;
                        done      <= (ret_state == DONE);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_collision_scanner.sv
// tb_collision_scanner: table vectors, hand-written stall/reset/restart sequences and random scans vs a reference model.
// Works with or without COLLISION_SHIP_EN defined.
module tb_collision_scanner;
    localparam int NA = 3;
    localparam int NS = 3;
    localparam int ES = 34;
`ifdef COLLISION_SHIP_EN
    localparam int SHIP_CYC = NA;
`else
    localparam int SHIP_CYC = 0;
`endif
    localparam int BASE = 1 + SHIP_CYC + NA * NS + NS + 1;
    localparam logic [ES-1:0] Z = '0;

    logic           clk = 1'b0;
    logic           reset_n, start, evt_ready;
    logic [ES-1:0]  ship;
    logic [NA*ES-1:0] asteroids;
    logic [NS*ES-1:0] shots;
    logic           evt_valid, busy, done, ship_hit;
    logic [1:0]     evt_type;
    logic [9:0]     evt_ast_addr, evt_shot_addr;

    collision_scanner #(
        .MAX_ASTEROIDS(NA), .MAX_SHOTS(NS), .ENTITY_SIZE(ES), .SCREEN_W(320), .SCREEN_H(240),
        .AST_SIZE(16), .SHOT_SIZE(2), .SHIP_SIZE(16)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .ship(ship), .asteroids(asteroids),
        .shots(shots), .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_type(evt_type),
        .evt_ast_addr(evt_ast_addr), .evt_shot_addr(evt_shot_addr), .busy(busy), .done(done),
        .ship_hit(ship_hit)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] t;
        int         a;
        int         s;
    } evt_t;

    typedef struct {
        string            name;
        logic [ES-1:0]    sh;
        logic [NA*ES-1:0] as;
        logic [NS*ES-1:0] sv;
        int               n;
        logic [1:0]       t;
        int               a;
        int               s;
        bit               hit;
    } vec_t;

    evt_t exp_q[$];
    evt_t got_q[$];
    vec_t vecs[8];
    int   errors = 0;
    int   checks = 0;

    task automatic check_output(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [ES-1:0] ent(input bit act, input int x, input int y, input logic [12:0] junk);
        logic [ES-1:0] e;
        e        = '0;
        e[0]     = act;
        e[5:1]   = junk[4:0];
        e[15:6]  = x[9:0];
        e[25:16] = y[9:0];
        e[33:26] = junk[12:5];
        return e;
    endfunction

    function automatic logic [3*ES-1:0] pack3(input logic [ES-1:0] e0, input logic [ES-1:0] e1,
                                              input logic [ES-1:0] e2);
        return {e2, e1, e0};
    endfunction

    function automatic int fx(input logic [ES-1:0] e);
        return int'(e[15:6]);
    endfunction

    function automatic int fy(input logic [ES-1:0] e);
        return int'(e[25:16]);
    endfunction

    function automatic bit ovl(input int ax, input int ay, input int aw, input int bx, input int by, input int bw);
        return (ax < bx + bw) && (bx < ax + aw) && (ay < by + bw) && (by < ay + aw);
    endfunction

    // Reference: walk the rule list directly over the entity tables, in scan order.
    task automatic build_model(input logic [ES-1:0] sh, input logic [NA*ES-1:0] as,
                               input logic [NS*ES-1:0] sv, output bit m_hit);
        bit ak[NA];
        bit sk[NS];
        logic [ES-1:0] a, s;
        exp_q.delete();
        m_hit = 1'b0;
        for (int i = 0; i < NA; i++) ak[i] = 1'b0;
        for (int j = 0; j < NS; j++) sk[j] = 1'b0;
`ifdef COLLISION_SHIP_EN
        for (int i = 0; i < NA; i++) begin
            a = as[i*ES +: ES];
            if (sh[0] && a[0] && !ak[i] && ovl(fx(sh), fy(sh), 16, fx(a), fy(a), 16)) begin
                exp_q.push_back('{2'd1, i, 0});
                ak[i] = 1'b1;
                m_hit = 1'b1;
            end
        end
`endif
        for (int i = 0; i < NA; i++) begin
            for (int j = 0; j < NS; j++) begin
                a = as[i*ES +: ES];
                s = sv[j*ES +: ES];
                if (a[0] && !ak[i] && s[0] && !sk[j] && ovl(fx(a), fy(a), 16, fx(s), fy(s), 2)) begin
                    exp_q.push_back('{2'd0, i, j});
                    ak[i] = 1'b1;
                    sk[j] = 1'b1;
                end
            end
        end
        for (int j = 0; j < NS; j++) begin
            s = sv[j*ES +: ES];
            if (s[0] && !sk[j] && (fx(s) >= 320 || fy(s) >= 240)) begin
                exp_q.push_back('{2'd2, 0, j});
                sk[j] = 1'b1;
            end
        end
    endtask

    // mode: 0 = ready always high, 1 = random ready, 2 = ready low for 5 valid cycles per event.
    task automatic apply_stimulus(input logic [ES-1:0] sh, input logic [NA*ES-1:0] as,
                                  input logic [NS*ES-1:0] sv, input int mode, input bit scramble,
                                  input bit restart, output int cyc, output int vcyc, output bit shit);
        bit         ok, was_stall;
        int         stall_cnt;
        logic [21:0] held;
        got_q.delete();
        ship      = sh;
        asteroids = as;
        shots     = sv;
        evt_ready = (mode != 2);
        ok        = 1'b0;
        was_stall = 1'b0;
        stall_cnt = 0;
        held      = '0;
        shit      = 1'b0;
        vcyc      = 0;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        for (int k = 0; k < 1000; k++) begin
            if (scramble && cyc == 2) begin
                ship = ent(1'b1, $urandom_range(0, 400), $urandom_range(0, 300), 13'($urandom));
                for (int i = 0; i < NA; i++)
                    asteroids[i*ES +: ES] = ent(1'b1, $urandom_range(0, 400), $urandom_range(0, 300), 13'($urandom));
                for (int j = 0; j < NS; j++)
                    shots[j*ES +: ES] = ent(1'b1, $urandom_range(0, 400), $urandom_range(0, 300), 13'($urandom));
            end
            start = restart && (cyc == 4);
            if (done) begin
                ok   = 1'b1;
                shit = ship_hit;
                break;
            end
            if (evt_valid) begin
                vcyc++;
                if (was_stall)
                    check_output("evt_stable", int'({evt_type, evt_ast_addr, evt_shot_addr}), int'(held));
                case (mode)
                    0:       evt_ready = 1'b1;
                    1:       evt_ready = ($urandom_range(0, 2) != 0);
                    default: evt_ready = (stall_cnt >= 5);
                endcase
                if (evt_ready) begin
                    got_q.push_back('{evt_type, int'(evt_ast_addr), int'(evt_shot_addr)});
                    was_stall = 1'b0;
                    stall_cnt = 0;
                end else begin
                    was_stall = 1'b1;
                    stall_cnt++;
                    held = {evt_type, evt_ast_addr, evt_shot_addr};
                end
            end else begin
                was_stall = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check_output("scan_done_seen", int'(ok), 1);
        @(negedge clk);
        check_output("done_pulse_busy", int'({done, busy}), 0);
    endtask

    task automatic compare_events(input string tag);
        check_output({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            check_output($sformatf("%s_evt%0d_type", tag, i), int'(got_q[i].t), int'(exp_q[i].t));
            check_output($sformatf("%s_evt%0d_ast", tag, i), got_q[i].a, exp_q[i].a);
            check_output($sformatf("%s_evt%0d_shot", tag, i), got_q[i].s, exp_q[i].s);
        end
    endtask

    task automatic set_vec(input int k, input string name, input logic [ES-1:0] sh, input logic [NA*ES-1:0] as,
                           input logic [NS*ES-1:0] sv, input int n, input logic [1:0] t, input int a,
                           input int s, input bit hit);
        vecs[k] = '{name, sh, as, sv, n, t, a, s, hit};
    endtask

    initial begin
        int   cyc, vcyc, x, y;
        bit   shit, m_hit, exp_pre;
        logic [ES-1:0]    r_sh;
        logic [NA*ES-1:0] r_as;
        logic [NS*ES-1:0] r_sv;

        set_vec(0, "all_off", Z, '0, '0, 0, 2'd0, 0, 0, 1'b0);
        set_vec(1, "ast1_shot2", Z, pack3(Z, ent(1, 100, 100, 0), Z), pack3(Z, Z, ent(1, 108, 108, 0)),
                1, 2'd0, 1, 2, 1'b0);
        set_vec(2, "shot_two_asts", Z, pack3(ent(1, 100, 100, 0), Z, ent(1, 101, 101, 0)),
                pack3(ent(1, 100, 100, 0), Z, Z), 1, 2'd0, 0, 0, 1'b0);
`ifdef COLLISION_SHIP_EN
        set_vec(3, "ship_ast", ent(1, 50, 50, 0), pack3(ent(1, 60, 60, 0), ent(1, 66, 50, 0), Z), '0,
                1, 2'd1, 0, 0, 1'b1);
        exp_pre = 1'b1;
`else
        set_vec(3, "ship_ast", ent(1, 50, 50, 0), pack3(ent(1, 60, 60, 0), ent(1, 66, 50, 0), Z), '0,
                0, 2'd0, 0, 0, 1'b0);
        exp_pre = 1'b0;
`endif
        set_vec(4, "oob_x", Z, '0, pack3(Z, ent(1, 320, 10, 0), Z), 1, 2'd2, 0, 1, 1'b0);
        set_vec(5, "touch_edge", Z, pack3(ent(1, 200, 100, 0), ent(0, 318, 238, 0), Z),
                pack3(ent(1, 216, 100, 0), ent(1, 319, 239, 0), Z), 0, 2'd0, 0, 0, 1'b0);
        set_vec(6, "oob_y", Z, '0, pack3(ent(1, 10, 240, 13'h1fff), Z, ent(0, 500, 500, 0)), 1, 2'd2, 0, 0, 1'b0);
        set_vec(7, "kill_before_oob", Z, pack3(ent(1, 310, 100, 0), ent(1, 312, 100, 0), Z),
                pack3(ent(1, 320, 100, 0), Z, Z), 1, 2'd0, 0, 0, 1'b0);

        reset_n   = 1'b0;
        start     = 1'b0;
        evt_ready = 1'b1;
        ship      = Z;
        asteroids = '0;
        shots     = '0;
        #12;
        check_output("reset_outputs", int'({evt_valid, evt_type, evt_ast_addr, evt_shot_addr, busy, done, ship_hit}), 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        for (int k = 0; k < 8; k++) begin
            apply_stimulus(vecs[k].sh, vecs[k].as, vecs[k].sv, 0, 1'b0, 1'b0, cyc, vcyc, shit);
            check_output({vecs[k].name, "_count"}, got_q.size(), vecs[k].n);
            if (vecs[k].n > 0 && got_q.size() > 0) begin
                check_output({vecs[k].name, "_type"}, int'(got_q[0].t), int'(vecs[k].t));
                check_output({vecs[k].name, "_ast"}, got_q[0].a, vecs[k].a);
                check_output({vecs[k].name, "_shot"}, got_q[0].s, vecs[k].s);
            end
            check_output({vecs[k].name, "_cycles"}, cyc, BASE + vecs[k].n);
            check_output({vecs[k].name, "_ship_hit"}, int'(shit), int'(vecs[k].hit));
            repeat (3) @(negedge clk);
            check_output({vecs[k].name, "_ship_hit_hold"}, int'(ship_hit), int'(vecs[k].hit));
        end

        $display("[TB] stalled out-of-bounds event");
        apply_stimulus(Z, '0, pack3(Z, ent(1, 320, 10, 0), Z), 2, 1'b0, 1'b0, cyc, vcyc, shit);
        check_output("stall_count", got_q.size(), 1);
        if (got_q.size() > 0)
            check_output("stall_evt", int'({got_q[0].t, 10'(got_q[0].a), 10'(got_q[0].s)}), int'({2'd2, 10'd0, 10'd1}));
        check_output("stall_valid_cycles", vcyc, 6);
        check_output("stall_cycles", cyc, BASE + 6);

        $display("[TB] start ignored while busy");
        apply_stimulus(Z, '0, '0, 0, 1'b0, 1'b1, cyc, vcyc, shit);
        check_output("restart_cycles", cyc, BASE);
        repeat (4) begin
            @(negedge clk);
            check_output("restart_no_requeue", int'(busy), 0);
        end

        $display("[TB] reset during EMIT");
        ship      = ent(1, 50, 50, 0);
        asteroids = pack3(ent(1, 60, 60, 0), Z, Z);
        shots     = pack3(Z, ent(1, 320, 10, 0), Z);
        evt_ready = 1'b0;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 100 && !evt_valid; k++) @(negedge clk);
        check_output("rst_evt_seen", int'(evt_valid), 1);
        check_output("rst_ship_hit_pre", int'(ship_hit), int'(exp_pre));
        #2 reset_n = 1'b0;
        #1 check_output("rst_async_clear", int'({evt_valid, busy, ship_hit, done}), 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        apply_stimulus(Z, '0, '0, 0, 1'b0, 1'b0, cyc, vcyc, shit);
        check_output("post_rst_count", got_q.size(), 0);
        check_output("post_rst_cycles", cyc, BASE);

        $display("[TB] random scans");
        for (int r = 0; r < 40; r++) begin
            r_sh = ent($urandom_range(0, 9) < 7, $urandom_range(80, 140), $urandom_range(80, 140), 13'($urandom));
            for (int i = 0; i < NA; i++)
                r_as[i*ES +: ES] = ent($urandom_range(0, 9) < 7, $urandom_range(80, 140),
                                       $urandom_range(80, 140), 13'($urandom));
            for (int j = 0; j < NS; j++) begin
                x = $urandom_range(80, 160);
                y = $urandom_range(80, 160);
                if ($urandom_range(0, 3) == 0) x = $urandom_range(300, 340);
                if ($urandom_range(0, 3) == 0) y = $urandom_range(225, 250);
                r_sv[j*ES +: ES] = ent($urandom_range(0, 9) < 7, x, y, 13'($urandom));
            end
            build_model(r_sh, r_as, r_sv, m_hit);
            apply_stimulus(r_sh, r_as, r_sv, 1, r[0], (r % 5) == 0, cyc, vcyc, shit);
            compare_events($sformatf("rnd%0d", r));
            check_output($sformatf("rnd%0d_cycles", r), cyc, BASE + vcyc);
            check_output($sformatf("rnd%0d_ship_hit", r), int'(shit), int'(m_hit));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
